mdio_responder: RTL and testbench
=================================

// Module: mdio_responder
// PURPOSE
//  Clause-22 MDIO management slave: the PHY-side end of the MDC/MDIO bus our FTop drives as master.
//  Decodes frames from an oversampled MDC/MDIO pair and answers reads/writes against a local 32x16 register file port.
//  Used as the on-chip PHY model for loopback bring-up and as a management target for FPGA-resident MMDs.
// PARAMETERS
//  PHY_ADDR     5'd7   PHYAD this responder answers to
//  BCAST_EN     1      1: also accept WRITE frames with PHYAD=0 (reads to 0 never answered)
//  PREAMBLE_MIN 32     consecutive 1s sampled on MDIO required before a start of frame (1..32)
//  SYNC_STAGES  2      synchronizer depth for mdc/mdd_i (>=2)
// PORTS
//  CLK          in   1   block clock; must be >=4x MDC frequency
//  RST          in   1   synchronous, active-high reset
//  mdc          in   1   management clock from master (asynchronous to CLK)
//  mdd_i        in   1   MDIO pad input
//  mdd_o        out  1   MDIO pad output value
//  mdd_oe       out  1   MDIO pad output enable (1 = drive)
//  reg_addr     out  5   REGAD of current frame
//  reg_rd_en    out  1   one-cycle read strobe
//  reg_rd_data  in   16  read data, valid the cycle after reg_rd_en
//  reg_wr_en    out  1   one-cycle write strobe
//  reg_wr_data  out  16  write data, valid with reg_wr_en
//  busy         out  1   high from ST detected until frame end/abort
//  frame_err    out  1   one-cycle pulse on bad ST, bad OP or preamble break mid-frame
// BEHAVIOUR
//  Reset: mdd_o=1, mdd_oe=0, reg_*_en=0, reg_addr=0, reg_wr_data=0, busy=0, frame_err=0, state=IDLE, preamble count=0.
//  mdc and mdd_i pass SYNC_STAGES flops; rise = sync_mdc & ~prev_mdc. All bit sampling occurs only on rise cycles.
//  Responder output changes only in the CLK cycle immediately following a rise (master samples on next rise).
//  States (advance one MDIO bit per rise):
//   IDLE:  count 1s (saturate at 32); a 0 with count>=PREAMBLE_MIN -> ST2 (that 0 is ST bit 1); a 0 otherwise clears count.
//   ST2:   expect 1 -> OP, busy=1; else frame_err, -> IDLE.
//   OP:    2 bits; 10=READ, 01=WRITE; 00/11 -> frame_err, IDLE.
//   PHYAD: 5 bits MSB first. REGAD: 5 bits MSB first; reg_addr updated when 5th bit captured.
//   After REGAD: match = (PHYAD==PHY_ADDR) or (BCAST_EN and PHYAD==0 and WRITE). No match -> SKIP.
//   READ path: reg_rd_en pulses the cycle after 5th REGAD bit; data latched into 16b shift reg next cycle.
//     TA1: mdd_oe stays 0. TA2: after that rise, mdd_oe=1, mdd_o=0.
//     DATA: 16 bits MSB first, each driven after a rise; after the rise ending bit 0, mdd_oe=0, mdd_o=1 -> IDLE.
//   WRITE path: TA 2 bits sampled, not checked. 16 data bits shifted in MSB first; on the 16th rise
//     reg_wr_data=shift, reg_wr_en pulses the next cycle -> IDLE.
//   SKIP: consume 18 bits (TA+data) without driving -> IDLE.
//  Preamble counter cleared on every frame exit; a new frame always needs a full preamble.
//  Reset asserted mid-frame: next cycle outputs at reset values (bus released), no strobes issued.
//  reg_rd_en and reg_wr_en never both high; at most one strobe per frame.
//  Ignores MDIO while busy except as frame bits; no preamble suppression support.
// STRUCTURE
//  Package mdio_pkg: state enum (IDLE,ST2,OP,PHYAD,REGAD,TA,RDATA,WDATA,SKIP), OP_READ=2'b10, OP_WRITE=2'b01, FRAME_BITS=32.
//  Sub-module mdio_edge_sync: SYNC_STAGES synchronizer + rise detect for mdc, synchronized mdd_i; reused by the master.
//  Top: FSM, 5b bit counter, 6b preamble counter, 16b shift register, output regs.
// TESTING (CLK=100MHz, MDC=2.5MHz unless stated)
//  1 32x1 preamble, READ PHYAD=7 REGAD=3, reg_rd_data=16'hBEEF -> rd_en once, reg_addr=3, TA2 drives 0, bus carries BEEF MSB first, oe=0 after.
//  2 WRITE PHYAD=7 REGAD=17 data 16'hA55A -> single wr_en, reg_wr_data=A55A, reg_addr=17, mdd_oe never 1.
//  3 READ to PHYAD=5 and READ to PHYAD=0 -> no strobes, mdd_oe=0 for whole frame; WRITE to 0 with BCAST_EN=1 -> wr_en.
//  4 Only 31 preamble 1s then frame -> ignored; ST=00 after valid preamble -> frame_err pulse, no strobes.
//  5 RST high during RDATA bit 8 -> next cycle mdd_oe=0, busy=0; following valid READ completes normally.
//  6 Back-to-back READ/WRITE frames with exactly PREAMBLE_MIN 1s, MDC=25MHz (CLK/4) -> both frames complete correctly.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO (Clause 22) definitions: frame FSM states, opcodes and frame geometry.
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam int         FRAME_BITS = 32;
  // TA plus data: the tail of a frame after the 14 header bits
  localparam int         TAIL_BITS  = FRAME_BITS - 14;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC/MDIO into the local clock domain and flags each synchronized MDC rising edge.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic i_mdc,
  input  logic i_mdd,
  output logic o_rise,
  output logic o_mdd
);

  logic [SYNC_STAGES-1:0] r_mdc_sync;
  logic [SYNC_STAGES-1:0] r_mdd_sync;
  logic                   r_mdc_prev;

  // Both lines see identical delay, so o_mdd is the bit present at the MDC edge
  always_ff @(posedge clk) begin
    if (srst) begin
      r_mdc_sync <= '0;
      r_mdd_sync <= '1;
      r_mdc_prev <= 1'b0;
    end else begin
      r_mdc_sync <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
      r_mdd_sync <= {r_mdd_sync[SYNC_STAGES-2:0], i_mdd};
      r_mdc_prev <= r_mdc_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
  assign o_mdd  = r_mdd_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO management slave: decodes frames from oversampled MDC/MDIO and
// serves reads/writes through a 32x16 register-file port.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd7,
  parameter bit         BCAST_EN     = 1'b1,
  parameter int         PREAMBLE_MIN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mdc,
  input  logic        mdd_i,
  output logic        mdd_o,
  output logic        mdd_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [5:0] PRE_MIN  = 6'(PREAMBLE_MIN);
  localparam logic [4:0] SKIP_END = 5'(TAIL_BITS - 1);

  logic        w_rise, w_bit, w_match;
  logic [1:0]  w_op;

  mdio_state_e r_state;
  logic [4:0]  r_bit_cnt, r_phyad, r_regad, r_reg_addr;
  logic [5:0]  r_pre_cnt;
  logic [15:0] r_shift, r_wr_data;
  logic        r_op_hi, r_is_read, r_rd_latch;
  logic        r_mdd_o, r_mdd_oe, r_rd_en, r_wr_en, r_busy, r_frame_err;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .srst  (RST),
    .i_mdc (mdc),
    .i_mdd (mdd_i),
    .o_rise(w_rise),
    .o_mdd (w_bit)
  );

  assign w_op    = {r_op_hi, w_bit};
  // Broadcast address is honoured for writes only; a read to it would collide on the bus
  assign w_match = (r_phyad == PHY_ADDR) || (BCAST_EN && (r_phyad == 5'd0) && !r_is_read);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_phyad     <= '0;
      r_regad     <= '0;
      r_reg_addr  <= '0;
      r_shift     <= '0;
      r_wr_data   <= '0;
      r_op_hi     <= 1'b0;
      r_is_read   <= 1'b0;
      r_rd_latch  <= 1'b0;
      r_mdd_o     <= 1'b1;
      r_mdd_oe    <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_latch  <= r_rd_en;
      if (r_rd_latch) r_shift <= reg_rd_data;
      if (w_rise) begin
        case (r_state)
          IDLE: begin
            if (w_bit) begin
              if (r_pre_cnt != 6'd32) r_pre_cnt <= r_pre_cnt + 6'd1;
            end else begin
              if (r_pre_cnt >= PRE_MIN) r_state <= ST2;
              r_pre_cnt <= '0;
            end
          end
          ST2: begin
            if (w_bit) begin
              r_state   <= OP;
              r_busy    <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
            end
          end
          OP: begin
            if (r_bit_cnt == 5'd0) begin
              r_op_hi   <= w_bit;
              r_bit_cnt <= 5'd1;
            end else begin
              r_bit_cnt <= '0;
              if (w_op == OP_READ || w_op == OP_WRITE) begin
                r_is_read <= (w_op == OP_READ);
                r_state   <= PHYAD;
              end else begin
                r_frame_err <= 1'b1;
                r_busy      <= 1'b0;
                r_state     <= IDLE;
              end
            end
          end
          PHYAD: begin
            r_phyad   <= {r_phyad[3:0], w_bit};
            r_bit_cnt <= (r_bit_cnt == 5'd4) ? 5'd0 : r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd4) r_state <= REGAD;
          end
          REGAD: begin
            r_regad   <= {r_regad[3:0], w_bit};
            r_bit_cnt <= (r_bit_cnt == 5'd4) ? 5'd0 : r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd4) begin
              r_reg_addr <= {r_regad[3:0], w_bit};
              r_state    <= w_match ? TA : SKIP;
              r_rd_en    <= w_match && r_is_read;
            end
          end
          TA: begin
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
              if (r_is_read) begin
                r_mdd_oe <= 1'b1;
                r_mdd_o  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= '0;
              r_state   <= r_is_read ? RDATA : WDATA;
              if (r_is_read) begin
                r_mdd_o <= r_shift[15];
                r_shift <= {r_shift[14:0], 1'b0};
              end
            end
          end
          RDATA: begin
            if (r_bit_cnt == 5'd15) begin
              r_mdd_oe  <= 1'b0;
              r_mdd_o   <= 1'b1;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_mdd_o   <= r_shift[15];
              r_shift   <= {r_shift[14:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          WDATA: begin
            r_shift <= {r_shift[14:0], w_bit};
            if (r_bit_cnt == 5'd15) begin
              r_wr_data <= {r_shift[14:0], w_bit};
              r_wr_en   <= 1'b1;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          SKIP: begin
            if (r_bit_cnt == SKIP_END) begin
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign mdd_o       = r_mdd_o;
  assign mdd_oe      = r_mdd_oe;
  assign reg_addr    = r_reg_addr;
  assign reg_rd_en   = r_rd_en;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_data = r_wr_data;
  assign busy        = r_busy;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: acts as MDIO master, samples the bus at each MDC rise.
module tb_mdio_responder;

  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] SOF = 2'b01;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mdc = 1'b1;
  logic        mdd_i = 1'b1;
  logic [15:0] reg_rd_data = 16'hBEEF;
  logic        mdd_o, mdd_oe, reg_rd_en, reg_wr_en, busy, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data;

  int total = 0;
  int bad = 0;
  int half = 20;

  int rd_cnt = 0, wr_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  logic [4:0]  rd_addr_seen = '0, wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;

  always #5 CLK = ~CLK;

  mdio_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .mdc        (mdc),
    .mdd_i      (mdd_i),
    .mdd_o      (mdd_o),
    .mdd_oe     (mdd_oe),
    .reg_addr   (reg_addr),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  // Strobe monitor
  always @(negedge CLK) begin
    if (reg_rd_en) begin rd_cnt++; rd_addr_seen = reg_addr; end
    if (reg_wr_en) begin wr_cnt++; wr_addr_seen = reg_addr; wr_data_seen = reg_wr_data; end
    if (reg_rd_en && reg_wr_en) both_cnt++;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic s_o, output logic s_oe, output logic s_busy);
    mdc = 1'b0;
    mdd_i = b;
    repeat (half) @(negedge CLK);
    s_o = mdd_o;
    s_oe = mdd_oe;
    s_busy = busy;
    mdc = 1'b1;
    repeat (half) @(negedge CLK);
  endtask

  task automatic frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                       input int rst_at,
                       output logic [31:0] ov, output logic [31:0] oev, output logic [31:0] bv);
    logic [31:0] f;
    logic so, soe, sb;
    f = {st, op, phy, ra, (op == RD) ? 18'h3FFFF : {2'b10, wd}};
    ov = '0; oev = '0; bv = '0;
    for (int i = 0; i < npre; i++) send_bit(1'b1, so, soe, sb);
    for (int i = 0; i < 32; i++) begin
      send_bit(f[31-i], so, soe, sb);
      ov[31-i] = so;
      oev[31-i] = soe;
      bv[31-i] = sb;
      if (i == rst_at) begin
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_oe", 32'(mdd_oe), 32'd0);
        chk("rst_o", 32'(mdd_o), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] ov, oev, bv;
    int r0, w0, f0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_mdd_o", 32'(mdd_o), 32'd1);
    chk("rst_mdd_oe", 32'(mdd_oe), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wr_data), 32'd0);
    chk("rst_strobes", 32'({reg_rd_en, reg_wr_en, frame_err}), 32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // 1: READ PHY 7 REG 3
    r0 = rd_cnt; w0 = wr_cnt;
    frame(32, SOF, RD, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    repeat (4) @(negedge CLK);
    $display("t1 read 7/3 bus=%h oe=%h", ov, oev);
    chk("t1_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    chk("t1_rd_addr", 32'(rd_addr_seen), 32'd3);
    chk("t1_reg_addr", 32'(reg_addr), 32'd3);
    chk("t1_oe", oev, 32'h0001_FFFF);
    chk("t1_bus", ov, {15'h7FFF, 1'b0, 16'hBEEF});
    chk("t1_busy", bv, 32'h3FFF_FFFF);
    chk("t1_release", 32'({busy, mdd_oe, mdd_o}), 32'd1);
    chk("t1_wr_cnt", 32'(wr_cnt - w0), 32'd0);

    // 2: WRITE PHY 7 REG 17
    r0 = rd_cnt; w0 = wr_cnt;
    frame(32, SOF, WR, 5'd7, 5'd17, 16'hA55A, -1, ov, oev, bv);
    repeat (4) @(negedge CLK);
    $display("t2 write 7/17 data=%h", reg_wr_data);
    chk("t2_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    chk("t2_wr_data", 32'(wr_data_seen), 32'hA55A);
    chk("t2_wr_addr", 32'(wr_addr_seen), 32'd17);
    chk("t2_oe", oev, 32'h0);
    chk("t2_busy", bv, 32'h3FFF_FFFF);
    chk("t2_rd_cnt", 32'(rd_cnt - r0), 32'd0);

    // 3: foreign and broadcast addresses
    r0 = rd_cnt; w0 = wr_cnt;
    frame(32, SOF, RD, 5'd5, 5'd3, 16'h0, -1, ov, oev, bv);
    $display("t3 read 5/3 oe=%h", oev);
    chk("t3_phy5_oe", oev, 32'h0);
    frame(32, SOF, RD, 5'd0, 5'd3, 16'h0, -1, ov, oev, bv);
    $display("t3 read 0/3 oe=%h", oev);
    chk("t3_phy0_oe", oev, 32'h0);
    chk("t3_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
    frame(32, SOF, WR, 5'd0, 5'd9, 16'h1234, -1, ov, oev, bv);
    repeat (4) @(negedge CLK);
    $display("t3 bcast write data=%h", wr_data_seen);
    chk("t3_bcast_wr", 32'(wr_cnt - w0), 32'd1);
    chk("t3_bcast_data", 32'(wr_data_seen), 32'h1234);
    chk("t3_bcast_rd", 32'(rd_cnt - r0), 32'd0);

    // 4: short preamble, bad ST, bad OP
    r0 = rd_cnt; w0 = wr_cnt; f0 = ferr_cnt;
    frame(31, SOF, RD, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    $display("t4 short preamble busy=%h", bv);
    chk("t4_short_busy", bv, 32'h0);
    chk("t4_short_oe", oev, 32'h0);
    frame(32, 2'b00, RD, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    repeat (4) @(negedge CLK);
    $display("t4 bad ST ferr=%0d", ferr_cnt - f0);
    chk("t4_st_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_st_busy", bv, 32'h0);
    frame(32, SOF, 2'b11, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    repeat (4) @(negedge CLK);
    $display("t4 bad OP ferr=%0d", ferr_cnt - f0);
    chk("t4_op_ferr", 32'(ferr_cnt - f0), 32'd2);
    chk("t4_op_busy", bv, 32'h3000_0000);
    chk("t4_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

    // 5: reset during RDATA bit 8 (frame bit 23), then a clean READ
    r0 = rd_cnt;
    reg_rd_data = 16'h8421;
    frame(32, SOF, RD, 5'd7, 5'd3, 16'h0, 23, ov, oev, bv);
    $display("t5 reset mid-read");
    chk("t5_rd_once", 32'(rd_cnt - r0), 32'd1);
    reg_rd_data = 16'h5AC3;
    frame(32, SOF, RD, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    $display("t5 read after reset bus=%h", ov);
    chk("t5_bus", ov, {15'h7FFF, 1'b0, 16'h5AC3});
    chk("t5_oe", oev, 32'h0001_FFFF);

    // 6: MDC = CLK/4, back-to-back READ then WRITE
    half = 2;
    r0 = rd_cnt; w0 = wr_cnt;
    reg_rd_data = 16'hC0DE;
    frame(32, SOF, RD, 5'd7, 5'd3, 16'h0, -1, ov, oev, bv);
    $display("t6 fast read bus=%h", ov);
    chk("t6_bus", ov, {15'h7FFF, 1'b0, 16'hC0DE});
    chk("t6_oe", oev, 32'h0001_FFFF);
    frame(32, SOF, WR, 5'd7, 5'd5, 16'h5AA5, -1, ov, oev, bv);
    repeat (8) @(negedge CLK);
    $display("t6 fast write data=%h", wr_data_seen);
    chk("t6_wr_data", 32'(wr_data_seen), 32'h5AA5);
    chk("t6_wr_addr", 32'(wr_addr_seen), 32'd5);
    chk("t6_counts", 32'({8'(rd_cnt - r0), 8'(wr_cnt - w0)}), 32'h0101);
    chk("t6_release", 32'({busy, mdd_oe}), 32'd0);
    chk("both_strobes", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
